alu_packet_ctrl: RTL and testbench
==================================

// Module: alu_packet_ctrl
// PURPOSE
//  Packet sequencer between the UART byte streams and the shared 32-bit ALU.
//  Parses the 4-byte header {opcode, reserved, len_lo, len_hi} (len = total bytes incl. header).
//  ECHO payload goes straight back to tx. ADD/MUL/DIV payload is folded left over 32-bit
//  little-endian operands on the ALU; the final 32-bit result is returned as 4 LE tx bytes.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  idle cycles mid-packet before abort (only with CTRL_TIMEOUT_EN)
// PORTS
//  clk_i           in   1   single clock
//  rst_ni          in   1   synchronous, active-low reset
//  rx_data_i       in   8   byte from UART rx
//  rx_valid_i      in   1   rx byte valid
//  rx_ready_o      out  1   controller accepts rx byte
//  tx_data_o       out  8   byte to UART tx
//  tx_valid_o      out  1   tx byte valid
//  tx_ready_i      in   1   UART tx accepts byte
//  alu_op_o        out  8   opcode (config_pkg OPCODE_ADD/MUL/DIV), stable while alu_valid_o
//  alu_a_o         out  32  accumulator operand
//  alu_b_o         out  32  new operand
//  alu_valid_o     out  1   ALU request; held until alu_ready_i
//  alu_ready_i     in   1   ALU accepts request
//  alu_result_i    in   32  ALU result
//  alu_done_i      in   1   result valid, one-cycle pulse
//  busy_o          out  1   state != IDLE
//  err_o           out  1   one-cycle pulse on malformed packet or abort
// BEHAVIOUR
//  Reset: state=IDLE; rx_ready_o, tx_valid_o, alu_valid_o, busy_o, err_o = 0; tx_data_o,
//   alu_a_o, alu_b_o = 0; counters cleared. Reset mid-packet drops all state; no partial tx.
//  Handshake: byte transfers on valid&&ready; tx_valid_o/tx_data_o held stable until tx_ready_i.
//  States: IDLE -> HDR -> {ECHO | OPND -> EXEC -> ... | DRAIN} -> RESP -> IDLE.
//  HDR: rx_ready_o=1; capture 4 bytes; 16-bit payload counter rem = len - 4.
//   len < 4 -> err_o, IDLE. len == 4 -> IDLE, no response, no error.
//   ECHO -> ECHO. ADD/MUL/DIV with rem%4==0 and rem>=8 -> OPND. Anything else -> DRAIN.
//  ECHO: 1-entry hold register; rx_ready_o = !hold_full || tx_ready_i (accept+send same cycle
//   allowed). Latency rx accept -> tx_valid_o = 1 cycle. IDLE when rem==0 and hold drained.
//  OPND: shift 4 LE bytes into operand reg; first operand loads acc (no ALU op); each later
//   operand -> EXEC with alu_a_o=acc, alu_b_o=operand. rx_ready_o=0 outside HDR/ECHO/OPND/DRAIN.
//  EXEC: alu_valid_o=1 until alu_ready_i; wait alu_done_i; acc<=alu_result_i (no masking; DIV by
//   zero returns whatever the ALU gives). rem>0 -> OPND, else RESP.
//  RESP: tx acc[7:0],[15:8],[23:16],[31:24] in order; IDLE after 4th handshake.
//  DRAIN: accept and discard rem bytes, pulse err_o on entry, IDLE at rem==0; nothing sent.
//  rem is 16-bit, decremented per accepted payload byte; never wraps (state exits at 0).
//  Back-to-back packets: HDR byte 0 of next packet may be accepted the cycle after IDLE entry.
// CONFIGURATION
//  CTRL_TIMEOUT_EN defined: counter resets on any rx/tx/ALU handshake; reaching TIMEOUT_CYCLES
//   in HDR/OPND/DRAIN/ECHO (rx stall only) -> err_o pulse, IDLE, hold register cleared.
//   Not applied in EXEC/RESP. Undefined: no counter, controller waits indefinitely.
// TESTING
//  1 ECHO len=17 "Hello, World!" byte-by-byte -> same 13 bytes out in order, err_o never set.
//  2 ADD len=12 ops 1,2 -> one ALU req a=1 b=2; tx 03 00 00 00.
//  3 MUL len=16 ops 2,3,4 -> ALU reqs (2,3),(6,4); tx 18 00 00 00.
//  4 DIV len=11 (rem=7) -> err_o pulse, 7 bytes drained, no tx; next ADD 5+6 -> 0B 00 00 00.
//  5 tx_ready_i low 20 cycles during ECHO/RESP -> tx_data_o stable, no byte lost or duplicated.
//  6 rst_ni low mid-OPND -> all outputs at reset values; fresh ADD 0xFFFFFFFF+1 -> 00 00 00 00.

Source files
------------

// File: rtl/alu_packet_ctrl.sv
// alu_packet_ctrl: parses {opcode, rsvd, len_lo, len_hi} packets; ECHO loops payload to tx, ADD/MUL/DIV fold LE words on the ALU.
// Latency: ECHO rx accept -> tx_valid_o 1 cycle; ALU packets reply 4 LE bytes once the last ALU result returns.
// Backpressure: rx_ready_o drops while the echo hold register cannot drain or during EXEC/RESP; tx/ALU requests held until accepted.
// Option: define CTRL_TIMEOUT_EN to abort packets that stall for TIMEOUT_CYCLES with an err_o pulse.
module alu_packet_ctrl #(
  parameter logic [7:0] OPCODE_ECHO = 8'h00,
  parameter logic [7:0] OPCODE_ADD  = 8'h01,
  parameter logic [7:0] OPCODE_MUL  = 8'h02,
  parameter logic [7:0] OPCODE_DIV  = 8'h03
`ifdef CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_valid_o,
  input  logic        alu_ready_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_done_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_ECHO, S_OPND, S_EXEC, S_RESP, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  hdr_cnt_q, byte_cnt_q, tx_idx_q;
  logic [7:0]  opcode_q, len_lo_q, hold_dat_q;
  logic [15:0] rem_q;
  logic        hold_full_q, first_q, alu_sent_q, err_q;
  logic [31:0] opnd_q, acc_q;

  logic        rx_fire, tx_fire, alu_fire, alu_take, err_set, tmo_hit, is_alu_op;
  logic [15:0] hdr_len, hdr_rem;
  logic [31:0] opnd_next;

  assign hdr_len   = {rx_data_i, len_lo_q};
  assign hdr_rem   = hdr_len - 16'd4;
  assign opnd_next = {rx_data_i, opnd_q[31:8]};
  assign is_alu_op = (opcode_q == OPCODE_ADD) || (opcode_q == OPCODE_MUL) || (opcode_q == OPCODE_DIV);

  assign rx_ready_o  = (state_q == S_HDR) || (state_q == S_OPND) || (state_q == S_DRAIN) ||
                       ((state_q == S_ECHO) && (rem_q != 16'd0) && (!hold_full_q || tx_ready_i));
  assign tx_valid_o  = ((state_q == S_ECHO) && hold_full_q) || (state_q == S_RESP);
  assign tx_data_o   = (state_q == S_RESP) ? acc_q[{tx_idx_q, 3'b000} +: 8] :
                       (state_q == S_ECHO) ? hold_dat_q : 8'h00;
  assign alu_valid_o = (state_q == S_EXEC) && !alu_sent_q;
  assign alu_op_o    = opcode_q;
  assign alu_a_o     = acc_q;
  assign alu_b_o     = opnd_q;
  assign busy_o      = (state_q != S_IDLE);
  assign err_o       = err_q;

  assign rx_fire  = rx_valid_i && rx_ready_o;
  assign tx_fire  = tx_valid_o && tx_ready_i;
  assign alu_fire = alu_valid_o && alu_ready_i;
  // A done pulse only counts once the request has been (or is being) accepted.
  assign alu_take = (state_q == S_EXEC) && alu_done_i && (alu_sent_q || alu_fire);

`ifdef CTRL_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        tmo_active, any_hs;
  // Echo only counts while waiting on rx; a tx stall is the far end's problem, not a dead packet.
  assign tmo_active = (state_q == S_HDR) || (state_q == S_OPND) || (state_q == S_DRAIN) ||
                      ((state_q == S_ECHO) && !hold_full_q);
  assign any_hs     = rx_fire || tx_fire || alu_fire || alu_take;
  assign tmo_hit    = tmo_active && !any_hs && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter, cleared by any handshake or outside the guarded states.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !tmo_active || any_hs) tmo_cnt_q <= '0;
    else                                  tmo_cnt_q <= tmo_cnt_q + 32'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode and error pulse request.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE:  if (rx_valid_i) state_d = S_HDR;
      S_HDR: begin
        if (rx_fire && (hdr_cnt_q == 2'd3)) begin
          if (hdr_len < 16'd4) begin
            state_d = S_IDLE;
            err_set = 1'b1;
          end else if (hdr_len == 16'd4) begin
            state_d = S_IDLE;
          end else if (opcode_q == OPCODE_ECHO) begin
            state_d = S_ECHO;
          end else if (is_alu_op && (hdr_rem[1:0] == 2'b00) && (hdr_rem >= 16'd8)) begin
            state_d = S_OPND;
          end else begin
            state_d = S_DRAIN;
            err_set = 1'b1;
          end
        end
      end
      S_ECHO:  if ((rem_q == 16'd0) && (!hold_full_q || tx_fire)) state_d = S_IDLE;
      S_OPND:  if (rx_fire && (byte_cnt_q == 2'd3) && !first_q) state_d = S_EXEC;
      S_EXEC:  if (alu_take) state_d = (rem_q != 16'd0) ? S_OPND : S_RESP;
      S_RESP:  if (tx_fire && (tx_idx_q == 2'd3)) state_d = S_IDLE;
      S_DRAIN: if (rx_fire && (rem_q == 16'd1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_d = S_IDLE;
      err_set = 1'b1;
    end
  end

  // Datapath: header capture, payload counting, echo hold, operand shift, accumulator, tx index.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hdr_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      tx_idx_q    <= '0;
      opcode_q    <= '0;
      len_lo_q    <= '0;
      hold_dat_q  <= '0;
      rem_q       <= '0;
      hold_full_q <= 1'b0;
      first_q     <= 1'b0;
      alu_sent_q  <= 1'b0;
      err_q       <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
    end else begin
      err_q <= err_set;
      case (state_q)
        S_IDLE: begin
          hdr_cnt_q   <= '0;
          byte_cnt_q  <= '0;
          tx_idx_q    <= '0;
          first_q     <= 1'b1;
          alu_sent_q  <= 1'b0;
          hold_full_q <= 1'b0;
        end
        S_HDR: if (rx_fire) begin
          hdr_cnt_q <= hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd0) opcode_q <= rx_data_i;
          if (hdr_cnt_q == 2'd2) len_lo_q <= rx_data_i;
          if (hdr_cnt_q == 2'd3) rem_q    <= hdr_rem;
        end
        S_ECHO: begin
          if (rx_fire) begin
            hold_dat_q  <= rx_data_i;
            hold_full_q <= 1'b1;
            rem_q       <= rem_q - 16'd1;
          end else if (tx_fire) begin
            hold_full_q <= 1'b0;
          end
        end
        S_OPND: if (rx_fire) begin
          opnd_q     <= opnd_next;
          byte_cnt_q <= byte_cnt_q + 2'd1;
          rem_q      <= rem_q - 16'd1;
          // The first word seeds the accumulator without an ALU operation.
          if ((byte_cnt_q == 2'd3) && first_q) begin
            acc_q   <= opnd_next;
            first_q <= 1'b0;
          end
        end
        S_EXEC: begin
          if (alu_fire) alu_sent_q <= 1'b1;
          if (alu_take) begin
            acc_q      <= alu_result_i;
            alu_sent_q <= 1'b0;
          end
        end
        S_RESP:  if (tx_fire) tx_idx_q <= tx_idx_q + 2'd1;
        S_DRAIN: if (rx_fire) rem_q <= rem_q - 16'd1;
        default: ;
      endcase
      if (tmo_hit) hold_full_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// tb_alu_packet_ctrl: table-driven packets with tx/ALU scoreboards plus hand-written corner sequences.
// Latency: ALU model accepts after 0-2 cycles and returns done 3 cycles after acceptance.
// Backpressure: tx_ready_i stalled for 20 cycles during ECHO and RESP.
module tb_alu_packet_ctrl;

  localparam logic [7:0] OP_ECHO = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_MUL  = 8'h02;
  localparam logic [7:0] OP_DIV  = 8'h03;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic        alu_valid_o;
  logic        alu_ready_i;
  logic [31:0] alu_result_i;
  logic        alu_done_i;
  logic        busy_o, err_o;

  alu_packet_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
    .alu_result_i(alu_result_i), .alu_done_i(alu_done_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  typedef struct {
    logic [7:0]  op;
    int          nops;
    logic [31:0] o [4];
    logic [31:0] res;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          err_cnt = 0;
  int          exp_err = 0;
  logic [7:0]  exp_tx [$];
  alu_req_t    exp_alu [$];
  logic [7:0]  pl [$];
  vec_t        vecs [8];
  alu_req_t    req, e;

  function automatic logic [31:0] alu_fn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_MUL:  return a * b;
      OP_DIV:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic vec_t mk(input logic [7:0] op, input int n, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d, input logic [31:0] res);
    vec_t v;
    v.op = op; v.nops = n; v.o[0] = a; v.o[1] = b; v.o[2] = c; v.o[3] = d; v.res = res;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) pl.push_back(w[8*k +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk_i);
    while (!rx_ready_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (!rx_ready_o) begin
      n_vec++;
      n_bad++;
      $display("FAIL rx_accept: byte %h not accepted within 3000 cycles", b);
    end
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  // Pushes the expected tx bytes / ALU requests / error for one packet, then sends it.
  task automatic send_pkt(input logic [7:0] op, input logic [15:0] len, input logic [31:0] res);
    int          rem;
    logic [31:0] acc, v;
    acc = '0;
    if (len < 16'd4) begin
      exp_err++;
    end else if (len > 16'd4) begin
      rem = int'(len) - 4;
      if (op == OP_ECHO) begin
        foreach (pl[i]) exp_tx.push_back(pl[i]);
      end else if ((op == OP_ADD || op == OP_MUL || op == OP_DIV) && (rem % 4 == 0) && rem >= 8) begin
        for (int k = 0; k < rem / 4; k++) begin
          v = {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]};
          if (k == 0) acc = v;
          else begin
            exp_alu.push_back('{op, acc, v});
            acc = alu_fn(op, acc, v);
          end
        end
        for (int k = 0; k < 4; k++) exp_tx.push_back(res[8*k +: 8]);
      end else begin
        exp_err++;
      end
    end
    send_byte(op);
    send_byte(8'h00);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    foreach (pl[i]) send_byte(pl[i]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk_i);
    while (busy_o && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    repeat (2) @(negedge clk_i);
    chk({name, "_idle"}, {31'd0, busy_o}, 32'd0);
    chk({name, "_err_count"}, err_cnt, exp_err);
    chk({name, "_tx_left"}, exp_tx.size(), 32'd0);
    chk({name, "_alu_left"}, exp_alu.size(), 32'd0);
  endtask

  // tx scoreboard: a stalled byte must equal the queue head, an accepted one is popped.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (err_o) err_cnt++;
        if (tx_valid_o) begin
          if (exp_tx.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL tx_extra: got byte %h with none expected", tx_data_o);
          end else if (tx_ready_i) begin
            chk("tx_byte", tx_data_o, exp_tx.pop_front());
          end else begin
            chk("tx_hold", tx_data_o, exp_tx[0]);
          end
        end
      end
    end
  end

  // ALU model: checks each request against the scoreboard, then returns the result.
  initial begin
    alu_ready_i  = 1'b0;
    alu_done_i   = 1'b0;
    alu_result_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_ni && alu_valid_o) begin
        repeat ($urandom_range(0, 2)) @(posedge clk_i);
        #1;
        req = '{alu_op_o, alu_a_o, alu_b_o};
        if (exp_alu.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL alu_extra: got op %h a %h b %h with none expected", req.op, req.a, req.b);
        end else begin
          e = exp_alu.pop_front();
          chk("alu_op", req.op, e.op);
          chk("alu_a", req.a, e.a);
          chk("alu_b", req.b, e.b);
        end
        alu_ready_i = 1'b1;
        @(posedge clk_i); #1;
        alu_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        alu_result_i = alu_fn(req.op, req.a, req.b);
        alu_done_i   = 1'b1;
        @(posedge clk_i); #1;
        alu_done_i = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
    $fatal(1);
  end

  initial begin
    string s;
    rst_ni     = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = '0;
    tx_ready_i = 1'b1;

    vecs[0] = mk(OP_ADD, 2, 32'd1, 32'd2, 0, 0, 32'h0000_0003);
    vecs[1] = mk(OP_MUL, 3, 32'd2, 32'd3, 32'd4, 0, 32'h0000_0018);
    vecs[2] = mk(OP_DIV, 2, 32'd100, 32'd7, 0, 0, 32'h0000_000E);
    vecs[3] = mk(OP_DIV, 2, 32'd5, 32'd0, 0, 0, 32'hFFFF_FFFF);
    vecs[4] = mk(OP_ADD, 4, 32'd10, 32'd20, 32'd30, 32'd40, 32'h0000_0064);
    vecs[5] = mk(OP_MUL, 2, 32'h0001_0000, 32'h0001_0000, 0, 0, 32'h0000_0000);
    vecs[6] = mk(OP_DIV, 3, 32'hFFFF_FFFF, 32'h10, 32'h2, 0, 32'h07FF_FFFF);
    vecs[7] = mk(OP_ADD, 2, 32'h8000_0001, 32'h8000_0000, 0, 0, 32'h0000_0001);

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_rx_ready", rx_ready_o, 0);
    chk("rst_tx_valid", tx_valid_o, 0);
    chk("rst_alu_valid", alu_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_tx_data", tx_data_o, 0);
    chk("rst_alu_a", alu_a_o, 0);
    chk("rst_alu_b", alu_b_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Echo of a text string.
    s = "Hello, World!";
    pl.delete();
    for (int i = 0; i < s.len(); i++) pl.push_back(s[i]);
    send_pkt(OP_ECHO, 16'd17, 0);
    wait_idle("echo_hello");

    // Arithmetic table.
    for (int v = 0; v < 8; v++) begin
      pl.delete();
      for (int k = 0; k < vecs[v].nops; k++) add_word(vecs[v].o[k]);
      send_pkt(vecs[v].op, 16'(4 + 4 * vecs[v].nops), vecs[v].res);
      wait_idle($sformatf("vec%0d", v));
    end

    // DIV with a 7-byte payload is drained, then a back-to-back ADD must still work.
    pl.delete();
    for (int i = 0; i < 7; i++) pl.push_back(8'(8'hA0 + i));
    send_pkt(OP_DIV, 16'd11, 0);
    pl.delete();
    add_word(32'd5);
    add_word(32'd6);
    send_pkt(OP_ADD, 16'd12, 32'h0000_000B);
    wait_idle("drain_then_add");

    // Header-only, short length, single operand, unknown opcode, 1-byte echo.
    pl.delete();
    send_pkt(OP_ADD, 16'd4, 0);
    wait_idle("len4");
    send_pkt(OP_MUL, 16'd2, 0);
    wait_idle("len2");
    add_word(32'h1234_5678);
    send_pkt(OP_ADD, 16'd8, 0);
    wait_idle("one_operand");
    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(8'(i));
    send_pkt(8'h7F, 16'd9, 0);
    wait_idle("bad_opcode");
    pl.delete();
    pl.push_back(8'h5A);
    send_pkt(OP_ECHO, 16'd5, 0);
    wait_idle("echo_one");

    // tx stalled 20 cycles during ECHO.
    s = "abcdef";
    pl.delete();
    for (int i = 0; i < s.len(); i++) pl.push_back(s[i]);
    tx_ready_i = 1'b0;
    fork
      send_pkt(OP_ECHO, 16'd10, 0);
      begin
        repeat (20) @(posedge clk_i);
        #1;
        tx_ready_i = 1'b1;
      end
    join
    wait_idle("echo_stall");

    // tx stalled 20 cycles during RESP.
    pl.delete();
    add_word(32'd7);
    add_word(32'd8);
    tx_ready_i = 1'b0;
    send_pkt(OP_ADD, 16'd12, 32'h0000_000F);
    repeat (20) @(posedge clk_i);
    #1;
    tx_ready_i = 1'b1;
    wait_idle("resp_stall");

    // Reset in the middle of OPND after the first operand has loaded.
    send_byte(OP_ADD);
    send_byte(8'h00);
    send_byte(8'd12);
    send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)));
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("mid_rst_rx_ready", rx_ready_o, 0);
    chk("mid_rst_tx_valid", tx_valid_o, 0);
    chk("mid_rst_alu_valid", alu_valid_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_tx_data", tx_data_o, 0);
    chk("mid_rst_alu_a", alu_a_o, 0);
    chk("mid_rst_alu_b", alu_b_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    pl.delete();
    add_word(32'hFFFF_FFFF);
    add_word(32'd1);
    send_pkt(OP_ADD, 16'd12, 32'h0000_0000);
    wait_idle("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
